// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Front-end pipeline control. It decodes the instruction sitting in IF/ID and
// compares it against the load in ID/EX. From that it drives the PC and IF/ID
// write enables and the IF/ID flush and ID/EX bubble controls. It also keeps a
// saturating count of the cycles lost to stalls and flushes.
//
// Precedence, highest first:
//   reset > memBusy (freeze) > taken branch (flush) > load-use (stall)
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   instruccionID  in   [31:0] instruction leaving IF/ID
//   idExMemRead    in   instruction in ID/EX is a load
//   idExRt         in   [4:0] destination register of the ID/EX load
//   branchTakenEX  in   one-cycle pulse: branch resolved taken in EX
//   memBusy        in   data memory not ready, front end must hold
//   pcEnable       out  PC write enable
//   ifIdEnable     out  IF/ID write enable
//   ifIdFlush      out  IF/ID loads a NOP
//   idExBubble     out  ID/EX loads a bubble
//   lostCycles     out  [CNT_WIDTH-1:0] saturating stall/flush cycle count
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instruccionID,
    input  logic                 idExMemRead,
    input  logic [4:0]           idExRt,
    input  logic                 branchTakenEX,
    input  logic                 memBusy,
    output logic                 pcEnable,
    output logic                 ifIdEnable,
    output logic                 ifIdFlush,
    output logic                 idExBubble,
    output logic [CNT_WIDTH-1:0] lostCycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 branch_pending_q, branch_pending_d;
    logic [CNT_WIDTH-1:0] lost_cycles_q, lost_cycles_d;

    // ------------------------------------------------------------------
    // Decode of the ID-stage instruction
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       load_use;
    logic       branch_now;
    logic       stall_now;
    logic       unused_imm;

    assign opcode = instruccionID[31:26];
    assign rs     = instruccionID[25:21];
    assign rt     = instruccionID[20:16];

    // The low half (rd/shamt/funct/immediate) never names a source register.
    assign unused_imm = ^instruccionID[15:0];

    // rt is only a source for R-type, beq, bne and sw. For loads and I-type
    // ALU ops it is a destination, so a match there is not a hazard.
    assign uses_rt = (opcode == 6'h00) || (opcode == 6'h04) ||
                     (opcode == 6'h05) || (opcode == 6'h2B);

    // $0 is hardwired, so a load "to" $0 never produces a value to wait for.
    assign load_use = idExMemRead && (idExRt != 5'd0) &&
                      ((idExRt == rs) || (uses_rt && (idExRt == rt)));

    // A taken branch seen while memory was busy is held until it can apply.
    assign branch_now = branchTakenEX || branch_pending_q;

    // LOAD_STALL masks load-use for one cycle. By then the load has moved on
    // to EX, and ID/EX holds the bubble we just inserted. Without the mask
    // the same dependent instruction would be stalled twice.
    assign stall_now = load_use && (state_q != LOAD_STALL);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            branch_pending_q <= 1'b0;
            lost_cycles_q    <= '0;
        end else begin
            state_q          <= state_d;
            branch_pending_q <= branch_pending_d;
            lost_cycles_q    <= lost_cycles_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: each combinational output gets a default on entry, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d          = RUN;
        branch_pending_d = branch_pending_q;
        if (memBusy) begin
            state_d = MEM_WAIT;
            if (branchTakenEX) begin
                branch_pending_d = 1'b1;
            end
        end else if (branch_now) begin
            state_d          = RUN;
            branch_pending_d = 1'b0;
        end else if (stall_now) begin
            state_d = LOAD_STALL;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (zero-cycle latency from the hazard inputs)
    // ------------------------------------------------------------------
    always_comb begin
        pcEnable   = 1'b1;
        ifIdEnable = 1'b1;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        if (reset) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (memBusy) begin
            // Freeze the front end. No bubble: ID/EX is held by the same
            // memory stall further down the pipe.
            pcEnable   = 1'b0;
            ifIdEnable = 1'b0;
        end else if (branch_now) begin
            // Kill the IF and ID instructions. Any load-use on the ID
            // instruction is moot because that instruction is discarded.
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (stall_now) begin
            pcEnable   = 1'b0;
            ifIdEnable = 1'b0;
            idExBubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lost-cycle counter: a cycle is lost when the PC is held or IF/ID is
    // flushed. The counter sticks at all-ones. Reset clears it in the
    // register block above.
    // ------------------------------------------------------------------
    always_comb begin
        lost_cycles_d = lost_cycles_q;
        if ((!pcEnable || ifIdFlush) && (lost_cycles_q != '1)) begin
            lost_cycles_d = lost_cycles_q + CNT_WIDTH'(1);
        end
    end

    assign lostCycles = lost_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Two instances share every input: the default 16-bit counter and a 4-bit
// counter used to exercise saturation. Each cycle, the bench pushes one
// expected observation to a scoreboard queue when it drives the inputs. It pops
// and compares that entry at the following falling edge.
// Control expectations are written as {pcEnable, ifIdEnable, ifIdFlush,
// idExBubble}.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] instruccionID;
    logic        idExMemRead;
    logic [4:0]  idExRt;
    logic        branchTakenEX;
    logic        memBusy;

    logic        pc16, ifid16, flush16, bub16;
    logic [15:0] lost16;
    logic        pc4, ifid4, flush4, bub4;
    logic [3:0]  lost4;

    hazard_unit dut (
        .clk           (clk),
        .reset         (reset),
        .instruccionID (instruccionID),
        .idExMemRead   (idExMemRead),
        .idExRt        (idExRt),
        .branchTakenEX (branchTakenEX),
        .memBusy       (memBusy),
        .pcEnable      (pc16),
        .ifIdEnable    (ifid16),
        .ifIdFlush     (flush16),
        .idExBubble    (bub16),
        .lostCycles    (lost16)
    );

    hazard_unit #(.CNT_WIDTH(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .instruccionID (instruccionID),
        .idExMemRead   (idExMemRead),
        .idExRt        (idExRt),
        .branchTakenEX (branchTakenEX),
        .memBusy       (memBusy),
        .pcEnable      (pc4),
        .ifIdEnable    (ifid4),
        .ifIdFlush     (flush4),
        .idExBubble    (bub4),
        .lostCycles    (lost4)
    );

    // Instruction encodings used below
    localparam logic [31:0] ADD_R10_R8_R9 = 32'h0109_5020; // rs=8  rt=9  R-type
    localparam logic [31:0] LW_R8_4_R9    = 32'h8D28_0004; // rs=9  rt=8  load
    localparam logic [31:0] ADD_R0_R0_R0  = 32'h0000_0020; // rs=0  rt=0
    localparam logic [31:0] SW_R9_0_R10   = 32'hAD49_0000; // rs=10 rt=9  store
    localparam logic [31:0] NOP           = 32'h0000_0000;

    localparam logic [3:0] C_RESET = 4'b1111; // reset and branch flush look alike
    localparam logic [3:0] C_FLUSH = 4'b1111;
    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_FREEZE= 4'b0000;
    localparam logic [3:0] C_STALL = 4'b0001;

    typedef struct packed {
        logic        rst;
        logic        mb;
        logic        bt;
        logic        mr;
        logic [4:0]  rt;
        logic [31:0] ins;
    } stim_t;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [3:0]  ctl4;
        logic [15:0] lost;
        logic [3:0]  lost4;
    } obs_t;

    obs_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] lost_ref  = '0;
    logic [3:0]  lost4_ref = '0;

    function automatic stim_t mk(input logic rst, input logic mb, input logic bt,
                                 input logic mr, input logic [4:0] rt,
                                 input logic [31:0] ins);
        stim_t s;
        s.rst = rst; s.mb = mb; s.bt = bt; s.mr = mr; s.rt = rt; s.ins = ins;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ctl   = {pc16, ifid16, flush16, bub16};
        o.ctl4  = {pc4, ifid4, flush4, bub4};
        o.lost  = lost16;
        o.lost4 = lost4;
        return o;
    endfunction

    // Drive one cycle's inputs just after the rising edge and record what
    // both instances must show for that cycle. The counter expectation is
    // the count of lost cycles before this one, saturating per width.
    task automatic drive(input stim_t s, input logic [3:0] ctl);
        obs_t e;
        @(posedge clk);
        #1;
        reset         = s.rst;
        memBusy       = s.mb;
        branchTakenEX = s.bt;
        idExMemRead   = s.mr;
        idExRt        = s.rt;
        instruccionID = s.ins;
        e.ctl   = ctl;
        e.ctl4  = ctl;
        e.lost  = lost_ref;
        e.lost4 = lost4_ref;
        exp_q.push_back(e);
        if (s.rst) begin
            lost_ref  = '0;
            lost4_ref = '0;
        end else if (!ctl[3] || ctl[1]) begin
            if (lost_ref  != 16'hFFFF) lost_ref  = lost_ref + 16'd1;
            if (lost4_ref != 4'hF)     lost4_ref = lost4_ref + 4'd1;
        end
    endtask

    task automatic test_reset();
        obs_t got, e;
        stim_t      s[$];
        logic [3:0] c[$];
        s.push_back(mk(1, 0, 0, 0, 0, NOP)); c.push_back(C_RESET);
        s.push_back(mk(1, 0, 0, 0, 0, NOP)); c.push_back(C_RESET);
        s.push_back(mk(0, 0, 0, 0, 0, NOP)); c.push_back(C_RUN);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i], c[i]);
            @(negedge clk);
            got = sample();
            e   = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got ctl=%b ctl4=%b lost=%0d lost4=%0d want ctl=%b lost=%0d lost4=%0d",
                         i, got.ctl, got.ctl4, got.lost, got.lost4, e.ctl, e.lost, e.lost4);
            end
        end
    endtask

    task automatic test_load_use();
        obs_t got, e;
        stim_t      s[$];
        logic [3:0] c[$];
        // rs match: one stall, then the same ID/EX state is masked
        s.push_back(mk(0, 0, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_STALL);
        s.push_back(mk(0, 0, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_RUN);
        // rt matches but lw does not read rt
        s.push_back(mk(0, 0, 0, 1, 5'd8, LW_R8_4_R9));    c.push_back(C_RUN);
        // register 0 never stalls
        s.push_back(mk(0, 0, 0, 1, 5'd0, ADD_R0_R0_R0));  c.push_back(C_RUN);
        // rt match through R-type
        s.push_back(mk(0, 0, 0, 1, 5'd9, ADD_R10_R8_R9)); c.push_back(C_STALL);
        s.push_back(mk(0, 0, 0, 1, 5'd9, ADD_R10_R8_R9)); c.push_back(C_RUN);
        // rt match through sw, then the load leaves
        s.push_back(mk(0, 0, 0, 1, 5'd9, SW_R9_0_R10));   c.push_back(C_STALL);
        s.push_back(mk(0, 0, 0, 0, 5'd9, SW_R9_0_R10));   c.push_back(C_RUN);
        // no load in ID/EX: no stall even on a matching register
        s.push_back(mk(0, 0, 0, 0, 5'd8, ADD_R10_R8_R9)); c.push_back(C_RUN);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i], c[i]);
            @(negedge clk);
            got = sample();
            e   = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL load_use[%0d]: got ctl=%b ctl4=%b lost=%0d lost4=%0d want ctl=%b lost=%0d lost4=%0d",
                         i, got.ctl, got.ctl4, got.lost, got.lost4, e.ctl, e.lost, e.lost4);
            end
        end
    endtask

    task automatic test_mem_branch();
        obs_t got, e;
        stim_t      s[$];
        logic [3:0] c[$];
        // Start from a clean counter so the 4-cycle cost is visible.
        s.push_back(mk(1, 0, 0, 0, 0, NOP));              c.push_back(C_RESET);
        s.push_back(mk(0, 1, 0, 0, 0, NOP));              c.push_back(C_FREEZE);
        s.push_back(mk(0, 1, 1, 0, 0, NOP));              c.push_back(C_FREEZE);
        s.push_back(mk(0, 1, 0, 0, 0, NOP));              c.push_back(C_FREEZE);
        s.push_back(mk(0, 0, 0, 0, 0, NOP));              c.push_back(C_FLUSH);
        s.push_back(mk(0, 0, 0, 0, 0, NOP));              c.push_back(C_RUN);
        s.push_back(mk(0, 0, 0, 0, 0, NOP));              c.push_back(C_RUN);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i], c[i]);
            @(negedge clk);
            got = sample();
            e   = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL mem_branch[%0d]: got ctl=%b ctl4=%b lost=%0d lost4=%0d want ctl=%b lost=%0d lost4=%0d",
                         i, got.ctl, got.ctl4, got.lost, got.lost4, e.ctl, e.lost, e.lost4);
            end
        end
        total++;
        if (lost16 !== 16'd4) begin
            bad++;
            $display("FAIL mem_branch_cost: got lost=%0d want 4", lost16);
        end
    endtask

    task automatic test_branch_vs_load();
        obs_t got, e;
        stim_t      s[$];
        logic [3:0] c[$];
        // Live branch and load-use together: the flush wins
        s.push_back(mk(0, 0, 1, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_FLUSH);
        s.push_back(mk(0, 0, 0, 1, 5'd8, NOP));           c.push_back(C_RUN);
        // Pending branch released together with a load-use: the flush wins
        s.push_back(mk(0, 1, 1, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_FREEZE);
        s.push_back(mk(0, 0, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_FLUSH);
        s.push_back(mk(0, 0, 0, 1, 5'd8, NOP));           c.push_back(C_RUN);
        // Memory busy during a load stall, then the stall applies normally
        s.push_back(mk(0, 0, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_STALL);
        s.push_back(mk(0, 1, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_FREEZE);
        s.push_back(mk(0, 0, 0, 0, 5'd8, ADD_R10_R8_R9)); c.push_back(C_RUN);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i], c[i]);
            @(negedge clk);
            got = sample();
            e   = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL branch_vs_load[%0d]: got ctl=%b ctl4=%b lost=%0d lost4=%0d want ctl=%b lost=%0d lost4=%0d",
                         i, got.ctl, got.ctl4, got.lost, got.lost4, e.ctl, e.lost, e.lost4);
            end
        end
    endtask

    task automatic test_saturate_and_reset();
        obs_t got, e;
        stim_t      s[$];
        logic [3:0] c[$];
        s.push_back(mk(1, 0, 0, 0, 0, NOP));              c.push_back(C_RESET);
        for (int k = 0; k < 20; k++) begin
            s.push_back(mk(0, 1, 0, 0, 0, NOP));          c.push_back(C_FREEZE);
        end
        // Reset in the middle of a memory freeze
        s.push_back(mk(1, 1, 0, 0, 0, NOP));              c.push_back(C_RESET);
        s.push_back(mk(0, 0, 0, 0, 0, NOP));              c.push_back(C_RUN);
        // Reset in the middle of a load stall: the next cycle is RUN again,
        // so the still-present hazard stalls afresh
        s.push_back(mk(0, 0, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_STALL);
        s.push_back(mk(1, 0, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_RESET);
        s.push_back(mk(0, 0, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_STALL);
        s.push_back(mk(0, 0, 0, 1, 5'd8, ADD_R10_R8_R9)); c.push_back(C_RUN);
        // Reset with a branch pending: it must not apply after release
        s.push_back(mk(0, 1, 1, 0, 0, NOP));              c.push_back(C_FREEZE);
        s.push_back(mk(1, 0, 0, 0, 0, NOP));              c.push_back(C_RESET);
        s.push_back(mk(0, 0, 0, 0, 0, NOP));              c.push_back(C_RUN);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i], c[i]);
            @(negedge clk);
            got = sample();
            e   = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL saturate_reset[%0d]: got ctl=%b ctl4=%b lost=%0d lost4=%0d want ctl=%b lost=%0d lost4=%0d",
                         i, got.ctl, got.ctl4, got.lost, got.lost4, e.ctl, e.lost, e.lost4);
            end
            // Cycle 21 is the reset cycle: the counters show the totals from
            // the 20 frozen cycles before it.
            if (i == 21) begin
                total++;
                if (lost4 !== 4'd15 || lost16 !== 16'd20) begin
                    bad++;
                    $display("FAIL saturation: got lost4=%0d lost=%0d want 15 and 20",
                             lost4, lost16);
                end
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        memBusy       = 1'b0;
        branchTakenEX = 1'b0;
        idExMemRead   = 1'b0;
        idExRt        = 5'd0;
        instruccionID = 32'h0;

        test_reset();
        test_load_use();
        test_mem_branch();
        test_branch_vs_load();
        test_saturate_and_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
